// File: rtl/lifo_reader_pkg.sv
// Shared types for the lifo_reader block: FSM states and skid-buffer occupancy.
// Optional stall timeout is enabled with the LIFO_READER_TIMEOUT_EN macro.
package lifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef logic [1:0] skid_occ_t;

  localparam skid_occ_t SKID_DEPTH = 2'd2;

  // A full skid can still accept a word when its head leaves in the same cycle.
  function automatic logic skid_has_room(input skid_occ_t occ, input logic take);
    return (occ < SKID_DEPTH) || ((occ == SKID_DEPTH) && take);
  endfunction

endpackage

// File: rtl/lifo_reader_skid.sv
// Two-entry valid/ready skid buffer carrying a last flag; the head entry drives
// the stream outputs directly from registers.
module lifo_reader_skid
  import lifo_reader_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_push_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output skid_occ_t         o_occ
);

  skid_occ_t         r_occ;
  logic [DATA_W-1:0] r_data_p0;
  logic [DATA_W-1:0] r_data_p1;
  logic              r_last_p0;
  logic              r_last_p1;
  logic              w_pop;

  assign o_valid = (r_occ != '0);
  assign o_data  = r_data_p0;
  assign o_last  = r_last_p0;
  assign o_occ   = r_occ;
  assign w_pop   = o_valid & i_ready;

  // p0 is the presented head entry, p1 the overflow entry behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ     <= '0;
      r_data_p0 <= '0;
      r_last_p0 <= 1'b0;
    end else begin
      if (i_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (!i_push && w_pop) begin
        r_occ <= r_occ - 1'b1;
      end

      if (w_pop) begin
        if (r_occ == 2'd2) begin
          r_data_p0 <= r_data_p1;
          r_last_p0 <= r_last_p1;
        end else if (i_push) begin
          r_data_p0 <= i_push_data;
          r_last_p0 <= i_push_last;
        end
      end else if (i_push && (r_occ == 2'd0)) begin
        r_data_p0 <= i_push_data;
        r_last_p0 <= i_push_last;
      end

      if (i_push && (((r_occ == 2'd1) && !w_pop) || ((r_occ == 2'd2) && w_pop))) begin
        r_data_p1 <= i_push_data;
        r_last_p1 <= i_push_last;
      end
    end
  end

endmodule

// File: rtl/lifo_reader.sv
// Pops a burst (or drains) from an attached lifo and streams it newest-first.
// Define LIFO_READER_TIMEOUT_EN to abort a burst after TMO empty stall cycles.
module lifo_reader
  import lifo_reader_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 8,
  parameter int TMO    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_W-1:0]           burst_len,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic                       lifo_r_req,
  input  logic [DATA_W-1:0]          lifo_r_data,
  input  logic                       lifo_empty,
  input  logic [$clog2(DEPTH+1)-1:0] lifo_cnt,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  input  logic                       out_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_done;
  logic             r_timeout;
  logic             r_tmo_flag;

  skid_occ_t        w_occ;
  logic             w_take;
  logic             w_room;
  logic             w_pop;
  logic             w_last_pop;
  logic             w_skid_drains;
  logic             w_tmo_expire;

  assign w_take     = out_valid & out_ready;
  assign w_room     = skid_has_room(w_occ, w_take);
  assign w_pop      = (r_state == POP) & ~lifo_empty & w_room;
  // A zero length means drain: the final pop is the one that takes the last word.
  assign w_last_pop = (r_len == '0) ? (lifo_cnt == CNT_W'(1))
                                    : (r_cnt == r_len - 1'b1);
  assign w_skid_drains = (w_occ == 2'd0) | ((w_occ == 2'd1) & w_take);

`ifdef LIFO_READER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || (r_state != STALL) || !lifo_empty) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo_expire = (r_state == STALL) & lifo_empty & (r_tmo_cnt == TMO_W'(TMO - 1));
`else
  // Without the timeout a stall never expires; TMO has no effect here.
  assign w_tmo_expire = (TMO < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_tmo_flag <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len      <= burst_len;
            r_cnt      <= '0;
            r_tmo_flag <= 1'b0;
            r_state    <= ((burst_len == '0) && lifo_empty) ? FLUSH : POP;
          end
        end
        POP: begin
          if (w_pop) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last_pop) begin
              r_state <= FLUSH;
            end
          end else if (lifo_empty) begin
            r_state <= (r_len != '0) ? STALL : FLUSH;
          end
        end
        STALL: begin
          if (!lifo_empty) begin
            r_state <= POP;
          end else if (w_tmo_expire) begin
            r_tmo_flag <= 1'b1;
            r_state    <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_skid_drains) begin
            r_done    <= 1'b1;
            r_timeout <= r_tmo_flag;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign lifo_r_req = w_pop;

  lifo_reader_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_pop),
    .i_push_data (lifo_r_data),
    .i_push_last (w_last_pop),
    .i_ready     (out_ready),
    .o_valid     (out_valid),
    .o_data      (out_data),
    .o_last      (out_last),
    .o_occ       (w_occ)
  );

endmodule

// File: tb/tb_lifo_reader.sv
// Bench for lifo_reader: behavioural lifo, stream monitor, table and random bursts.
module tb_lifo_reader;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int LEN_W  = 8;
  localparam int TMO    = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef LIFO_READER_TIMEOUT_EN
  localparam int EXP_TMO_PULSES = 1;
`else
  localparam int EXP_TMO_PULSES = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  burst_len = '0;
  logic              out_ready = 1'b0;
  logic              busy, done, timeout, lifo_r_req, out_valid, out_last;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] lifo_r_data;
  logic              lifo_empty;
  logic [CNT_W-1:0]  lifo_cnt;

  always #5 clk = ~clk;

  lifo_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .busy(busy),
    .done(done), .timeout(timeout), .lifo_r_req(lifo_r_req),
    .lifo_r_data(lifo_r_data), .lifo_empty(lifo_empty), .lifo_cnt(lifo_cnt),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  // Behavioural lifo: occupancy = pushes - pops - dropped.
  logic [DATA_W-1:0] mem [0:15];
  int n_push = 0, n_pop = 0, n_drop = 0, sp;
  logic pop_pend = 1'b0;

  always_comb begin
    sp          = n_push - n_pop - n_drop;
    lifo_empty  = (sp == 0);
    lifo_cnt    = CNT_W'(sp);
    lifo_r_data = (sp > 0) ? mem[sp-1] : '0;
  end

  // Stream monitor and abstract skid occupancy (words popped but not yet accepted)
  int cyc = 0, done_cnt = 0, done_cyc = 0, tmo_cnt = 0;
  bit last_done_tmo = 1'b0;
  int stab_err = 0, pop_empty_err = 0, skid_err = 0;
  int hs_total = 0, pop_base = 0, outst = 0;
  bit resync = 1'b1, hold_prev = 1'b0, hold_l = 1'b0;
  logic [DATA_W-1:0] hold_d = '0;
  logic [DATA_W-1:0] got_d[$];
  bit got_l[$];
  int got_c[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop_pend) n_pop <= n_pop + 1;
  end

  always @(negedge clk) begin
    pop_pend = lifo_r_req;
    if (lifo_r_req && lifo_empty) pop_empty_err++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      last_done_tmo = timeout;
    end
    if (timeout) tmo_cnt++;
    if (rst) begin
      resync = 1'b1;
      hold_prev = 1'b0;
    end else begin
      if (resync) begin
        resync = 1'b0;
        pop_base = n_pop - hs_total;
      end else begin
        outst = n_pop - hs_total - pop_base;
        if (lifo_r_req && outst >= 2 && !(out_valid && out_ready)) skid_err++;
        if (out_valid != (outst > 0)) skid_err++;
      end
      if (hold_prev && !(out_valid && out_data == hold_d && out_last == hold_l)) stab_err++;
      hold_prev = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
    end
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      got_c.push_back(cyc);
      hs_total++;
    end
  end

  // Sink: 0 = always ready, 1 = toggling, 2 = random
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int n_chk = 0, n_err = 0;
  logic [DATA_W-1:0] exp_d[$];

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cur_sp();
    return n_push - n_pop - n_drop;
  endfunction

  task automatic push(input logic [DATA_W-1:0] d);
    mem[cur_sp()] = d;
    n_push++;
  endtask

  task automatic clear_lifo();
    n_drop = n_push - n_pop;
  endtask

  task automatic fill_lifo(input int n);
    for (int i = 0; i < n; i++) push(DATA_W'($urandom));
  endtask

  // Expected stream: the n newest words, newest first.
  task automatic snapshot(input int n);
    int s;
    s = cur_sp();
    exp_d.delete();
    for (int i = 0; i < n; i++) exp_d.push_back(mem[s-1-i]);
  endtask

  task automatic kick(input int blen);
    burst_len = LEN_W'(blen);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_burst(input string nm, input int base, input int d0,
                              input bit exp_last, input bit exp_tmo, input int budget);
    int n, k;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    chk({nm, "_done_seen"}, (done_cnt != d0), 1);
    n = got_d.size() - base;
    chk({nm, "_words"}, n, exp_d.size());
    for (int i = 0; i < exp_d.size() && i < n; i++) begin
      chk({nm, "_data"}, got_d[base+i], exp_d[i]);
      chk({nm, "_last"}, got_l[base+i], (exp_last && i == exp_d.size() - 1));
    end
    chk({nm, "_timeout"}, last_done_tmo, exp_tmo);
    if (n > 0 && !exp_tmo && done_cnt != d0)
      chk({nm, "_done_lat"}, done_cyc - got_c[got_c.size()-1], 1);
    repeat (3) step();
    chk({nm, "_one_done"}, done_cnt - d0, 1);
  endtask

  task automatic run_vec(input string nm, input int fill, input int blen, input int mode,
                         input int exp_words, input int exp_rem);
    int base, d0;
    clear_lifo();
    fill_lifo(fill);
    rdy_mode = mode;
    base = got_d.size();
    d0 = done_cnt;
    snapshot(exp_words);
    kick(blen);
    finish_burst(nm, base, d0, exp_words > 0, 1'b0, 2000);
    chk({nm, "_rem"}, cur_sp(), exp_rem);
  endtask

  typedef struct {
    int fill;
    int blen;
    int mode;
    int exp_words;
    int exp_rem;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base, d0, fill, blen, pushed, d;
    logic [DATA_W-1:0] w;

    tbl[0] = '{3, 3, 0, 3, 0};
    tbl[1] = '{3, 3, 1, 3, 0};
    tbl[2] = '{5, 0, 0, 5, 0};
    tbl[3] = '{5, 0, 2, 5, 0};
    tbl[4] = '{0, 0, 0, 0, 0};
    tbl[5] = '{6, 2, 2, 2, 4};
    tbl[6] = '{8, 8, 1, 8, 0};
    tbl[7] = '{4, 1, 0, 1, 3};

    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_req", lifo_r_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), tbl[i].fill, tbl[i].blen, tbl[i].mode,
              tbl[i].exp_words, tbl[i].exp_rem);

    // Throughput with a ready sink: three words on consecutive cycles
    run_vec("thru", 3, 3, 0, 3, 0);
    chk("thru_b2b", got_c[got_c.size()-1] - got_c[got_c.size()-3], 2);

    // Drain start on an empty lifo: done two cycles after start, no data
    clear_lifo();
    rdy_mode = 0;
    base = got_d.size();
    d0 = done_cnt;
    kick(0);
    @(negedge clk);
    chk("empty_busy", busy, 1);
    chk("empty_done_early", done, 0);
    step();
    @(negedge clk);
    chk("empty_done", done, 1);
    chk("empty_tmo", timeout, 0);
    step();
    chk("empty_words", got_d.size() - base, 0);

`ifdef LIFO_READER_TIMEOUT_EN
    // Stall that never resolves: aborted after TMO empty cycles
    clear_lifo();
    fill_lifo(2);
    rdy_mode = 0;
    base = got_d.size();
    d0 = done_cnt;
    snapshot(2);
    kick(4);
    finish_burst("tmo", base, d0, 1'b0, 1'b1, 500);
    d = done_cyc - got_c[got_c.size()-1];
    chk("tmo_lat_window", (d >= TMO && d <= TMO + 3), 1);
`else
    // Stall until the missing words arrive twenty cycles later
    clear_lifo();
    fill_lifo(2);
    rdy_mode = 0;
    base = got_d.size();
    d0 = done_cnt;
    snapshot(2);
    kick(4);
    repeat (19) step();
    chk("stall_busy", busy, 1);
    chk("stall_req", lifo_r_req, 0);
    chk("stall_words_so_far", got_d.size() - base, 2);
    push(16'hA5A5);
    push(16'h5A5A);
    exp_d.push_back(16'h5A5A);
    exp_d.push_back(16'hA5A5);
    finish_burst("stall", base, d0, 1'b1, 1'b0, 500);
`endif

    // Reset in the middle of a 6-word burst, then a normal drain
    clear_lifo();
    fill_lifo(6);
    rdy_mode = 0;
    base = got_d.size();
    d0 = done_cnt;
    kick(6);
    for (int k = 0; k < 100 && got_d.size() - base < 2; k++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_req", lifo_r_req, 0);
    rst = 1'b0;
    repeat (3) step();
    chk("mid_rst_no_done", done_cnt - d0, 0);
    base = got_d.size();
    d0 = done_cnt;
    d = cur_sp();
    snapshot(d);
    kick(0);
    finish_burst("post_rst", base, d0, d > 0, 1'b0, 500);

    // Start while busy must not relaunch or change the length
    clear_lifo();
    fill_lifo(5);
    rdy_mode = 1;
    base = got_d.size();
    d0 = done_cnt;
    snapshot(3);
    kick(3);
    step();
    burst_len = LEN_W'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    finish_burst("busy_start", base, d0, 1'b1, 1'b0, 500);
    chk("busy_start_rem", cur_sp(), 2);

    // Maximum length: the popped-word counter must not wrap
    clear_lifo();
    rdy_mode = 0;
    base = got_d.size();
    d0 = done_cnt;
    exp_d.delete();
    pushed = 0;
    kick(255);
    for (int k = 0; k < 5000 && done_cnt == d0; k++) begin
      if (cur_sp() == 0 && pushed < 255) begin
        w = DATA_W'($urandom);
        push(w);
        exp_d.push_back(w);
        pushed++;
      end
      step();
    end
    finish_burst("len255", base, d0, 1'b1, 1'b0, 100);

    // Random bursts against the stack model with a random sink
    for (int it = 0; it < 20; it++) begin
      fill = $urandom_range(0, 8);
      blen = $urandom_range(0, fill);
      run_vec($sformatf("rnd%0d", it), fill, blen, 2,
              (blen == 0) ? fill : blen, (blen == 0) ? 0 : fill - blen);
    end

    chk("hold_stable_errs", stab_err, 0);
    chk("pop_empty_errs", pop_empty_err, 0);
    chk("skid_occ_errs", skid_err, 0);
    chk("timeout_pulses", tmo_cnt, EXP_TMO_PULSES);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
